inbuf_skew_sched: RTL

//  Read scheduler for the ROWS input buffers that feed the systolic array's west edge.
//  On start, streams LEN words out of every row buffer with a diagonal skew: row r begins r cycles after row 0.

---
 rtl/systola_pkg.sv | 9 +
 rtl/inbuf_skew_sched_if.sv | 24 ++
 rtl/inbuf_skew_sched.sv | 87 ++++++++
 3 files changed

// File: rtl/systola_pkg.sv
// Shared types and constants for the systolic-array feed logic.
package systola_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} sched_state_t;

   // Cycles from a buffer read strobe to its data at the array edge
   localparam int BUF_RD_LAT = 1;

endpackage

// File: rtl/inbuf_skew_sched_if.sv
// Handshake bundle between the sequencer/row buffers (master) and the read scheduler (slave).
interface inbuf_skew_sched_if #(
   parameter int ROWS = 4,
   parameter int LENW = 5
);
   logic            start;
   logic [LENW-1:0] len;
   logic [ROWS-1:0] buf_empty;
   logic [ROWS-1:0] rd_en;
   logic [ROWS-1:0] valid_out;
   logic            busy;
   logic            done;
   logic            stalled;

   modport master (
      output start, len, buf_empty,
      input  rd_en, valid_out, busy, done, stalled
   );

   modport slave (
      input  start, len, buf_empty,
      output rd_en, valid_out, busy, done, stalled
   );
endinterface

// File: rtl/inbuf_skew_sched.sv
// Diagonal-skew read scheduler for the west-edge row buffers: row r lags row 0 by r steps,
// and every row stalls together whenever any active row's buffer is empty.
module inbuf_skew_sched
   import systola_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int LENW = 5
) (
   input logic              clk,
   input logic              rst,
   inbuf_skew_sched_if.slave bus
);

   // Step counter spans 0 .. len_q+ROWS-2 without wrapping
   localparam int CW = LENW + $clog2(ROWS) + 1;

   sched_state_t    state, next_state;
   logic [CW-1:0]   cnt;
   logic [LENW-1:0] len_q;
   logic [ROWS-1:0] act;
   logic [ROWS-1:0] rd_en;
   logic [ROWS-1:0] rd_pipe [BUF_RD_LAT];
   logic            stall;
   logic            step_ok;
   logic            last_step;
   logic            done_q;

   for (genvar r = 0; r < ROWS; r++) begin : g_act
      assign act[r] = (cnt >= CW'(r)) && (cnt < CW'(r) + CW'(len_q));
   end

   assign stall     = |(act & bus.buf_empty);
   assign step_ok   = (state == S_RUN) && !stall;
   assign last_step = (cnt + CW'(1)) == (CW'(len_q) + CW'(ROWS - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         len_q <= '0;
      end else begin
         state <= next_state;
         if (state == S_IDLE && bus.start) begin
            len_q <= bus.len;
            cnt   <= '0;
         end else if (step_ok) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE:  if (bus.start) next_state = (bus.len == '0) ? S_FIN : S_RUN;
         S_RUN:   if (step_ok && last_step) next_state = S_FIN;
         S_FIN:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      rd_en = '0;
      if (step_ok) rd_en = act;
   end

   // NOTE: the read-latency delay line is reset so no stale strobe escapes after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
         for (int i = 0; i < BUF_RD_LAT; i++) rd_pipe[i] <= '0;
      end else begin
         done_q     <= (next_state == S_FIN);
         rd_pipe[0] <= rd_en;
         for (int i = 1; i < BUF_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   assign bus.rd_en     = rd_en;
   assign bus.valid_out = rd_pipe[BUF_RD_LAT-1];
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done_q;
   assign bus.stalled   = (state == S_RUN) && stall;

endmodule
